alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multicycle controller that executes one ALU instruction at a time against the existing regfile, alucontrol and alu blocks.
- Accepts a 16-bit instruction over a valid/ready handshake and sequences operand read, execute and write-back.
- Holds the architectural PSR flag register and drives regfile ports and ALU operands; regfile, alucontrol and alu remain external.

Parameters:
- WIDTH, 16, datapath and instruction width
- REGS_AW, 4, regfile address width (16 registers)

Ports:
- clk in 1: system clock; all state updates on rising edge
- reset_n in 1: reset is asynchronous and active-low
- instr_valid in 1: instruction offered
- instr in 16: op[15:12], Rdest[11:8], opext/immhi[7:4], Rsrc/immlo[3:0]
- instr_ready out 1: sequencer can accept
- ra1 out 4: regfile read address, Rsrc
- ra2 out 4: regfile read address, Rdest
- rd1 in 16: regfile read data for ra1 (combinational read)
- rd2 in 16: regfile read data for ra2
- wa out 4: regfile write address
- wd out 16: regfile write data
- regwrite out 1: regfile write enable
- alu_rsrc out 16: latched source operand (register or extended immediate) to alu Rsrc
- alu_rdest out 16: latched Rdest operand to alu Rdest
- alu_opcode out 4: opcode to alucontrol
- alu_opext out 4: opext to alucontrol
- alu_result in 16: alu result
- alu_psr in 5: alu flags {N,Z,L,F,C} = [4:0]
- psr out 5: architectural flags, same bit order
- done out 1: one-cycle pulse at write-back
- illegal out 1: one-cycle pulse for unsupported encoding

Behaviour:
- Encodings. op=0000 is register form with opext: AND 0001, OR 0010, XOR 0011, ADD 0101, SUB 1001, CMP 1011, MOV 1101. A nonzero op equal to one of those codes is the immediate form of that operation, with imm8 = instr[7:0]. Everything else is illegal.
- Immediate extension: ADD, SUB and CMP sign-extend imm8; AND, OR, XOR and MOV zero-extend.
- States: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid, latch instr and go to READ.
- READ: ra1=Rsrc and ra2=Rdest are driven from the latched instr. At the clock edge, latch rd2 into the Rdest operand and latch either rd1 or the extended immediate into the Rsrc operand, then go to EXEC. An illegal decode instead pulses illegal and returns to IDLE with no write-back.
- EXEC: alu_* outputs are stable from the latched operands and latched op/opext. Latch alu_result. For ADD, SUB and CMP, psr <= alu_psr; other ops leave psr unchanged. Go to WB.
- WB: regwrite=1 with wa=Rdest and wd=result, except CMP/CMPI, which hold regwrite=0. done=1. instr_ready=1: accepting here goes straight to READ, otherwise go to IDLE.
- Latency: accept at edge 0, write commits at edge 3, done high in the cycle before edge 3.
- Throughput: back-to-back, one instruction per 3 cycles.
- Hazard: the write commits at the WB edge, before the next READ, so a dependent instruction sees new data with no stall.
- regwrite is 0 in every state except WB.
- alu_opcode/alu_opext hold the latched values in all states (0 after reset).
- Reset values (async, immediate on reset_n=0): state IDLE, instr_ready 1, done 0, illegal 0, regwrite 0, wa 0, ra1 0, ra2 0, wd 0, alu_* 0, psr 0.
- Reset in WB suppresses the write, because regwrite drops asynchronously.
- instr_valid while instr_ready=0 is ignored; the instruction is not latched.
- Arithmetic is entirely in the alu: wrap at 16 bits, no carry-in.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode/opext constants (OP_RTYPE, OP_AND ... OP_MOV)
  - state encoding
  - PSR bit indices (PSR_C=0, PSR_F=1, PSR_L=2, PSR_Z=3, PSR_N=4)
- Sub-module alu_seq_decode (combinational). Inputs: latched instr. Outputs: is_imm, sign_ext, writes_reg, writes_psr, illegal, ext_imm[15:0].

Test Plan:
- Reg ADD: R1=0xFFFF, R2=0xFFFF, instr 0x0251 (ADD R1,R2) -> after 3 cycles R2=0xFFFE, psr[0]=1, done pulse once, regwrite exactly one cycle.
- CMP no write-back: R1=0x0001, R2=0x0001, instr 0x02B1 -> psr[3]=1, regwrite never asserted, R2 still 0x0001.
- Immediate sign-extend: R3=0x0005, ADDI instr 0x53FF -> R3=0x0004. ORI 0x2380 -> R3=0x0084 (zero-extend).
- Logical keeps flags: after a CMP sets Z=1, XOR 0x0231 -> psr unchanged, R2=R1^R2.
- Back-to-back: instr_valid held high with two dependent ADDs (R2+=R1 twice, R1=1, R2=0) -> accepts at 3-cycle spacing, final R2=2.
- Illegal then reset: instr 0x0061 -> illegal pulse, no regwrite. Then assert reset_n=0 during WB of a valid ADD -> regwrite drops immediately, psr=0, instr_ready=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU instruction sequencer: opcode/opext codes,
// controller state encoding, PSR flag bit positions and small decode helpers.
package alu_seq_pkg;

    // Opcode / opext codes (register form uses op = OP_RTYPE with opext)
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_AND   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h9;
    localparam logic [3:0] OP_CMP   = 4'hB;
    localparam logic [3:0] OP_MOV   = 4'hD;

    // PSR flag bit indices, psr = {N,Z,L,F,C}
    localparam int PSR_C = 0;
    localparam int PSR_F = 1;
    localparam int PSR_L = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;
    localparam int PSR_W = 5;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // True for any operation code this sequencer knows how to execute
    function automatic logic is_supported(input logic [3:0] code);
        case (code)
            OP_AND, OP_OR, OP_XOR, OP_ADD,
            OP_SUB, OP_CMP, OP_MOV: is_supported = 1'b1;
            default:                is_supported = 1'b0;
        endcase
    endfunction

    // True for the arithmetic group: sign-extended immediates, PSR update
    function automatic logic is_arith(input logic [3:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_CMP: is_arith = 1'b1;
            default:                is_arith = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational decode of a latched instruction: form, immediate extension,
// write-back/PSR side effects and legality.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] instr,
    output logic             is_imm,
    output logic             sign_ext,
    output logic             writes_reg,
    output logic             writes_psr,
    output logic             illegal,
    output logic [WIDTH-1:0] ext_imm
);

    logic [3:0] op_s;
    logic [3:0] opext_s;
    logic [3:0] code_s;
    logic       legal_s;
    logic [7:0] imm8_s;

    assign op_s    = instr[15:12];
    assign opext_s = instr[7:4];
    assign imm8_s  = instr[7:0];

    // Pick the effective operation code and classify the encoding
    always_comb begin
        code_s  = 4'h0;
        legal_s = 1'b0;
        is_imm  = 1'b0;
        if (op_s == OP_RTYPE) begin
            code_s  = opext_s;
            is_imm  = 1'b0;
            legal_s = is_supported(opext_s);
        end else begin
            code_s  = op_s;
            is_imm  = 1'b1;
            legal_s = is_supported(op_s);
        end
        sign_ext   = legal_s & is_imm & is_arith(code_s);
        writes_reg = legal_s & (code_s != OP_CMP);
        writes_psr = legal_s & is_arith(code_s);
        illegal    = ~legal_s;
    end

    // Extend imm8 to the datapath width; arithmetic ops sign-extend
    always_comb begin
        if (sign_ext) begin
            ext_imm = {{(WIDTH-8){imm8_s[7]}}, imm8_s};
        end else begin
            ext_imm = {{(WIDTH-8){1'b0}}, imm8_s};
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle controller executing one ALU instruction at a time:
// IDLE -> READ (operand fetch) -> EXEC (latch result/flags) -> WB (write-back).
// Holds the architectural PSR; regfile, alucontrol and alu are external.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGS_AW = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               instr_valid,
    input  logic [WIDTH-1:0]   instr,
    output logic               instr_ready,
    output logic [REGS_AW-1:0] ra1,
    output logic [REGS_AW-1:0] ra2,
    input  logic [WIDTH-1:0]   rd1,
    input  logic [WIDTH-1:0]   rd2,
    output logic [REGS_AW-1:0] wa,
    output logic [WIDTH-1:0]   wd,
    output logic               regwrite,
    output logic [WIDTH-1:0]   alu_rsrc,
    output logic [WIDTH-1:0]   alu_rdest,
    output logic [3:0]         alu_opcode,
    output logic [3:0]         alu_opext,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [PSR_W-1:0]   alu_psr,
    output logic [PSR_W-1:0]   psr,
    output logic               done,
    output logic               illegal
);

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   instr_r;
    logic [WIDTH-1:0]   rsrc_r;
    logic [WIDTH-1:0]   rdest_r;
    logic [WIDTH-1:0]   result_r;
    logic [PSR_W-1:0]   psr_r;
    logic [WIDTH-1:0]   rsrc_sel_s;

    logic               accept_s;
    logic               instr_ready_s;
    logic               regwrite_s;
    logic               done_s;
    logic               illegal_s;

    logic               dec_is_imm_s;
    logic               dec_sign_ext_s;
    logic               dec_writes_reg_s;
    logic               dec_writes_psr_s;
    logic               dec_illegal_s;
    logic [WIDTH-1:0]   dec_ext_imm_s;

    alu_seq_decode #(
        .WIDTH      (WIDTH)
    ) u_decode (
        .instr      (instr_r),
        .is_imm     (dec_is_imm_s),
        .sign_ext   (dec_sign_ext_s),
        .writes_reg (dec_writes_reg_s),
        .writes_psr (dec_writes_psr_s),
        .illegal    (dec_illegal_s),
        .ext_imm    (dec_ext_imm_s)
    );

    // State register; reset returns to IDLE so regwrite drops immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-state control; outputs depend only on registers
    always_comb begin
        state_next_s  = state_r;
        accept_s      = 1'b0;
        instr_ready_s = 1'b0;
        regwrite_s    = 1'b0;
        done_s        = 1'b0;
        illegal_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                instr_ready_s = 1'b1;
                if (instr_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (dec_illegal_s) begin
                    illegal_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_WB;
            end
            ST_WB: begin
                instr_ready_s = 1'b1;
                done_s        = 1'b1;
                regwrite_s    = dec_writes_reg_s;
                if (instr_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_READ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Source operand: register data for R-form, extended immediate otherwise
    always_comb begin
        case ({dec_is_imm_s, dec_sign_ext_s})
            2'b00:   rsrc_sel_s = rd1;
            2'b10:   rsrc_sel_s = dec_ext_imm_s;
            2'b11:   rsrc_sel_s = dec_ext_imm_s;
            default: rsrc_sel_s = rd1;
        endcase
    end

    // Instruction latch; only loads on an accepted handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            instr_r <= instr;
        end
    end

    // Operand latches, loaded at the end of a legal READ
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsrc_r  <= {WIDTH{1'b0}};
            rdest_r <= {WIDTH{1'b0}};
        end else if ((state_r == ST_READ) && !dec_illegal_s) begin
            rsrc_r  <= rsrc_sel_s;
            rdest_r <= rd2;
        end
    end

    // Result and PSR capture at the end of EXEC; only arithmetic ops touch flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_r <= {WIDTH{1'b0}};
            psr_r    <= {PSR_W{1'b0}};
        end else if (state_r == ST_EXEC) begin
            result_r <= alu_result;
            if (dec_writes_psr_s) begin
                psr_r <= alu_psr;
            end
        end
    end

    assign instr_ready = instr_ready_s;
    assign regwrite    = regwrite_s;
    assign done        = done_s;
    assign illegal     = illegal_s;
    assign ra1         = instr_r[3:0];
    assign ra2         = instr_r[11:8];
    assign wa          = instr_r[11:8];
    assign wd          = result_r;
    assign alu_rsrc    = rsrc_r;
    assign alu_rdest   = rdest_r;
    assign alu_opcode  = instr_r[15:12];
    assign alu_opext   = instr_r[7:4];
    assign psr         = psr_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural regfile and ALU.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  ra1, ra2, wa;
    logic [15:0] rd1, rd2, wd;
    logic        regwrite;
    logic [15:0] alu_rsrc, alu_rdest, alu_result;
    logic [3:0]  alu_opcode, alu_opext;
    logic [4:0]  alu_psr, psr;
    logic        done, illegal;

    logic [15:0] rf [16];
    logic        pre_we;
    logic [3:0]  pre_a;
    logic [15:0] pre_d;

    int compared;
    int mismatched;

    alu_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .wa          (wa),
        .wd          (wd),
        .regwrite    (regwrite),
        .alu_rsrc    (alu_rsrc),
        .alu_rdest   (alu_rdest),
        .alu_opcode  (alu_opcode),
        .alu_opext   (alu_opext),
        .alu_result  (alu_result),
        .alu_psr     (alu_psr),
        .psr         (psr),
        .done        (done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: combinational read, write on rising edge
    always @(posedge clk) begin
        if (pre_we) rf[pre_a] <= pre_d;
        else if (regwrite) rf[wa] <= wd;
    end
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    // ALU model: result = Rdest op Rsrc, flags {N,Z,L,F,C}
    always_comb begin
        logic [3:0]  code;
        logic [16:0] sum, dif;
        code = (alu_opcode == 4'h0) ? alu_opext : alu_opcode;
        sum  = {1'b0, alu_rdest} + {1'b0, alu_rsrc};
        dif  = {1'b0, alu_rdest} - {1'b0, alu_rsrc};
        alu_result = 16'h0000;
        alu_psr    = 5'b00000;
        case (code)
            4'h1: alu_result = alu_rdest & alu_rsrc;
            4'h2: alu_result = alu_rdest | alu_rsrc;
            4'h3: alu_result = alu_rdest ^ alu_rsrc;
            4'hD: alu_result = alu_rsrc;
            4'h5: begin
                alu_result = sum[15:0];
                alu_psr[0] = sum[16];
                alu_psr[1] = (alu_rdest[15] == alu_rsrc[15]) && (sum[15] != alu_rdest[15]);
            end
            4'h9, 4'hB: begin
                alu_result = dif[15:0];
                alu_psr[0] = dif[16];
                alu_psr[1] = (alu_rdest[15] != alu_rsrc[15]) && (dif[15] != alu_rdest[15]);
                alu_psr[2] = alu_rdest < alu_rsrc;
            end
            default: alu_result = 16'h0000;
        endcase
        alu_psr[3] = (alu_result == 16'h0000);
        alu_psr[4] = alu_result[15];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_a = a; pre_d = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one instruction from IDLE and count strobes over the next 4 cycles
    task automatic run(input logic [15:0] ins, output int n_rw, output int n_done, output int n_ill);
        int k;
        k = 0;
        n_rw = 0; n_done = 0; n_ill = 0;
        @(negedge clk);
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
        instr = ins; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_rw   += int'(regwrite);
            n_done += int'(done);
            n_ill  += int'(illegal);
        end
    endtask

    initial begin
        int nrw, ndone, nill, acc;
        int t [2];
        compared = 0; mismatched = 0;
        reset_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
        pre_we = 1'b0; pre_a = 4'h0; pre_d = 16'h0000;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;

        // Reset state
        #12;
        chk("rst_ready",    {31'd0, instr_ready}, 32'd1);
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_done_ill", {30'd0, done, illegal}, 32'd0);
        chk("rst_psr",      {27'd0, psr}, 32'd0);
        chk("rst_addr_wd",  {4'd0, ra1, ra2, wa, wd}, 32'd0);
        chk("rst_alu",      {alu_rsrc, alu_rdest}, 32'd0);
        chk("rst_op",       {24'd0, alu_opcode, alu_opext}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Register ADD with carry
        preload(4'd1, 16'hFFFF);
        preload(4'd2, 16'hFFFF);
        run(16'h0251, nrw, ndone, nill);
        chk("add_r2",   {16'd0, rf[2]}, 32'h0000FFFE);
        chk("add_psr",  {27'd0, psr}, 32'h11);
        chk("add_rw",   nrw, 32'd1);
        chk("add_done", ndone, 32'd1);

        // CMP: flags only, no write-back
        preload(4'd1, 16'h0001);
        preload(4'd2, 16'h0001);
        run(16'h02B1, nrw, ndone, nill);
        chk("cmp_psr",  {27'd0, psr}, 32'h08);
        chk("cmp_rw",   nrw, 32'd0);
        chk("cmp_r2",   {16'd0, rf[2]}, 32'h00000001);
        chk("cmp_done", ndone, 32'd1);

        // XOR keeps flags from CMP
        preload(4'd1, 16'h0F0F);
        preload(4'd2, 16'h00FF);
        run(16'h0231, nrw, ndone, nill);
        chk("xor_r2",  {16'd0, rf[2]}, 32'h00000FF0);
        chk("xor_psr", {27'd0, psr}, 32'h08);

        // ADDI sign-extends, ORI zero-extends
        preload(4'd3, 16'h0005);
        run(16'h53FF, nrw, ndone, nill);
        chk("addi_r3",  {16'd0, rf[3]}, 32'h00000004);
        chk("addi_psr", {27'd0, psr}, 32'h01);
        run(16'h2380, nrw, ndone, nill);
        chk("ori_r3",   {16'd0, rf[3]}, 32'h00000084);
        chk("ori_psr",  {27'd0, psr}, 32'h01);

        // Back-to-back dependent ADDs with valid held high
        preload(4'd1, 16'h0001);
        preload(4'd2, 16'h0000);
        instr = 16'h0251; instr_valid = 1'b1;
        acc = 0; nrw = 0; t[0] = 0; t[1] = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nrw += int'(regwrite);
            if (instr_valid && instr_ready && acc < 2) begin
                t[acc] = i;
                acc++;
            end
            @(posedge clk);
            #1;
            if (acc >= 2) instr_valid = 1'b0;
        end
        chk("b2b_accepts", acc, 32'd2);
        chk("b2b_spacing", t[1] - t[0], 32'd3);
        chk("b2b_r2",      {16'd0, rf[2]}, 32'h00000002);
        chk("b2b_rw",      nrw, 32'd2);

        // Illegal encoding
        run(16'h0061, nrw, ndone, nill);
        chk("ill_pulse", nill, 32'd1);
        chk("ill_rw",    nrw, 32'd0);
        chk("ill_done",  ndone, 32'd0);

        // Reset during WB suppresses the write
        preload(4'd1, 16'hFFFF);
        preload(4'd2, 16'hFFFF);
        @(negedge clk);
        instr = 16'h0251; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("wb_rw_before",  {31'd0, regwrite}, 32'd1);
        chk("wb_psr_before", {27'd0, psr}, 32'h11);
        #2 reset_n = 1'b0;
        #1;
        chk("rstwb_rw",    {31'd0, regwrite}, 32'd0);
        chk("rstwb_psr",   {27'd0, psr}, 32'd0);
        chk("rstwb_ready", {31'd0, instr_ready}, 32'd1);
        chk("rstwb_done",  {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("rstwb_r2", {16'd0, rf[2]}, 32'h0000FFFF);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
